// File: rtl/scratch_pad_arbiter.sv
// scratch_pad_arbiter
// Shares one single-port, read-first, 1-cycle-latency scratch pad RAM between
// PORTS requesters. Each port has a one-deep request register. An arbiter
// issues at most one registered RAM command per cycle. Read data returns
// through a per-port output register that honours stall backpressure.
// Optional build macro: SCRATCH_PAD_ARB_FIXED_PRIORITY_EN selects
// lowest-index-first arbitration instead of the default round-robin.
module scratch_pad_arbiter #(
    parameter int PORTS            = 4,
    parameter int WIDTH            = 64,
    parameter int ADDR_WIDTH       = 12,
    parameter int PORTS_ADDR_WIDTH = $clog2(PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [0:PORTS-1]              rd_en,
    input  logic [0:PORTS-1]              wr_en,
    input  logic [ADDR_WIDTH*PORTS-1:0]   addr,
    input  logic [WIDTH*PORTS-1:0]        d,
    output logic [0:PORTS-1]              full,
    output logic [WIDTH*PORTS-1:0]        q,
    output logic [0:PORTS-1]              valid,
    input  logic [0:PORTS-1]              stall,
    output logic                          mem_rd_en,
    output logic                          mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]              mem_d,
    input  logic [WIDTH-1:0]              mem_q
);

    localparam int PW  = PORTS_ADDR_WIDTH;
    localparam int PW1 = PORTS_ADDR_WIDTH + 1;

    // Request holding registers
    logic [0:PORTS-1]        req_v_q, req_v_d;
    logic [0:PORTS-1]        req_rd_q, req_rd_d;
    logic [0:PORTS-1]        req_wr_q, req_wr_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q [PORTS];
    logic [ADDR_WIDTH-1:0]   req_addr_d [PORTS];
    logic [WIDTH-1:0]        req_d_q [PORTS];
    logic [WIDTH-1:0]        req_d_d [PORTS];

    // Arbitration
    logic [0:PORTS-1]        busy;
    logic [0:PORTS-1]        eligible;
    logic [0:PORTS-1]        grant;
    logic                    grant_v;
    logic [PW-1:0]           grant_idx;
`ifndef SCRATCH_PAD_ARB_FIXED_PRIORITY_EN
    logic [PW-1:0]           ptr_q, ptr_d;
`endif

    // Command stage (drives the RAM pins directly)
    logic                    mem_rd_en_q, mem_rd_en_d;
    logic                    mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]        mem_d_q, mem_d_d;
    logic [PW-1:0]           cmd_tag_q, cmd_tag_d;

    // mem_q stage and per-port output registers
    logic                    rsp_v_q, rsp_v_d;
    logic [PW-1:0]           rsp_tag_q, rsp_tag_d;
    logic [0:PORTS-1]        valid_q, valid_d;
    logic [WIDTH-1:0]        q_q [PORTS];
    logic [WIDTH-1:0]        q_d [PORTS];

    // A port is busy while its single outstanding read is anywhere in the return path
    always_comb begin
        busy     = '0;
        eligible = '0;
        for (int i = 0; i < PORTS; i++) begin
            busy[i] = (mem_rd_en_q && (cmd_tag_q == PW'(i))) ||
                      (rsp_v_q && (rsp_tag_q == PW'(i))) ||
                      valid_q[i];
            eligible[i] = req_v_q[i] && (!req_rd_q[i] || !busy[i]);
        end
    end

`ifdef SCRATCH_PAD_ARB_FIXED_PRIORITY_EN
    // Fixed priority: scan from the highest index down so the lowest eligible index wins last
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                grant_v   = 1'b1;
                grant_idx = PW'(k);
            end
        end
    end
`else
    // Round-robin: scan ptr+PORTS-1 down to ptr so the first eligible port from ptr wins last
    always_comb begin
        logic [PW1-1:0] sum;
        logic [PW-1:0]  idx;
        grant_v   = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + PW1'(k);
            if (sum >= PW1'(PORTS)) begin
                sum = sum - PW1'(PORTS);
            end
            idx = sum[PW-1:0];
            if (eligible[idx]) begin
                grant_v   = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Pointer moves just past the granted port and holds when nothing is granted
    always_comb begin
        ptr_d = ptr_q;
        if (grant_v) begin
            if (grant_idx == PW'(PORTS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // One-hot view of the grant, used for full and for releasing the request slot
    always_comb begin
        grant = '0;
        for (int i = 0; i < PORTS; i++) begin
            grant[i] = grant_v && (grant_idx == PW'(i));
        end
    end

    assign full = req_v_q & ~grant;

    // Capture a new request whenever the slot is empty or being granted this cycle
    always_comb begin
        req_v_d    = req_v_q;
        req_rd_d   = req_rd_q;
        req_wr_d   = req_wr_q;
        req_addr_d = req_addr_q;
        req_d_d    = req_d_q;
        for (int i = 0; i < PORTS; i++) begin
            if ((rd_en[i] || wr_en[i]) && !full[i]) begin
                req_v_d[i]    = 1'b1;
                req_rd_d[i]   = rd_en[i];
                req_wr_d[i]   = wr_en[i];
                req_addr_d[i] = addr[(PORTS-1-i)*ADDR_WIDTH +: ADDR_WIDTH];
                req_d_d[i]    = d[(PORTS-1-i)*WIDTH +: WIDTH];
            end else if (grant[i]) begin
                req_v_d[i] = 1'b0;
            end
        end
    end

    // Register the granted request onto the RAM pins; address and data hold when idle
    always_comb begin
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_d_d     = mem_d_q;
        cmd_tag_d   = cmd_tag_q;
        if (grant_v) begin
            mem_rd_en_d = req_rd_q[grant_idx];
            mem_wr_en_d = req_wr_q[grant_idx];
            mem_addr_d  = req_addr_q[grant_idx];
            mem_d_d     = req_d_q[grant_idx];
            cmd_tag_d   = grant_idx;
        end
    end

    // Return path: tag follows the read into the mem_q stage, then lands in the port register
    always_comb begin
        rsp_v_d   = mem_rd_en_q;
        rsp_tag_d = cmd_tag_q;
        valid_d   = valid_q;
        q_d       = q_q;
        for (int i = 0; i < PORTS; i++) begin
            if (valid_q[i] && !stall[i]) begin
                valid_d[i] = 1'b0;
            end
            if (rsp_v_q && (rsp_tag_q == PW'(i))) begin
                valid_d[i] = 1'b1;
                q_d[i]     = mem_q;
            end
        end
    end

    // Request holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_v_q  <= '0;
            req_rd_q <= '0;
            req_wr_q <= '0;
            for (int i = 0; i < PORTS; i++) begin
                req_addr_q[i] <= '0;
                req_d_q[i]    <= '0;
            end
        end else begin
            req_v_q    <= req_v_d;
            req_rd_q   <= req_rd_d;
            req_wr_q   <= req_wr_d;
            req_addr_q <= req_addr_d;
            req_d_q    <= req_d_d;
        end
    end

    // Command stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_d_q     <= '0;
            cmd_tag_q   <= '0;
        end else begin
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_d_q     <= mem_d_d;
            cmd_tag_q   <= cmd_tag_d;
        end
    end

    // mem_q stage and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_v_q   <= 1'b0;
            rsp_tag_q <= '0;
            valid_q   <= '0;
            for (int i = 0; i < PORTS; i++) begin
                q_q[i] <= '0;
            end
        end else begin
            rsp_v_q   <= rsp_v_d;
            rsp_tag_q <= rsp_tag_d;
            valid_q   <= valid_d;
            q_q       <= q_d;
        end
    end

    // Pack the per-port read data with port 0 in the most-significant slice
    always_comb begin
        q = '0;
        for (int i = 0; i < PORTS; i++) begin
            q[(PORTS-1-i)*WIDTH +: WIDTH] = q_q[i];
        end
    end

    assign valid     = valid_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_d     = mem_d_q;

endmodule

// File: tb/tb_scratch_pad_arbiter.sv
// Testbench for scratch_pad_arbiter: table-driven vectors plus hand-written
// sequences for stall backpressure, reset mid-operation and arbitration order.
module tb_scratch_pad_arbiter;

    localparam int PORTS = 4;
    localparam int WIDTH = 64;
    localparam int AW    = 12;

    logic                  clk;
    logic                  rst;
    logic [0:PORTS-1]      rd_en;
    logic [0:PORTS-1]      wr_en;
    logic [AW*PORTS-1:0]   addr;
    logic [WIDTH*PORTS-1:0] d;
    logic [0:PORTS-1]      full;
    logic [WIDTH*PORTS-1:0] q;
    logic [0:PORTS-1]      valid;
    logic [0:PORTS-1]      stall;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [AW-1:0]         mem_addr;
    logic [WIDTH-1:0]      mem_d;
    logic [WIDTH-1:0]      mem_q;

    int num_compared;
    int num_mismatched;

    scratch_pad_arbiter #(
        .PORTS(PORTS),
        .WIDTH(WIDTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rd_en(rd_en),
        .wr_en(wr_en),
        .addr(addr),
        .d(d),
        .full(full),
        .q(q),
        .valid(valid),
        .stall(stall),
        .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr),
        .mem_d(mem_d),
        .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten RAM words read back as a recognisable address-dependent pattern
    function automatic logic [63:0] pattern_word(input logic [7:0] a);
        return 64'hC0DE_0000_0000_0000 | {56'd0, a};
    endfunction

    // Behavioural single-port, read-first, 1-cycle-latency RAM
    logic [WIDTH-1:0] ram [0:255];
    logic [255:0]     ram_written = '0;
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_q <= ram_written[mem_addr[7:0]] ? ram[mem_addr[7:0]] : pattern_word(mem_addr[7:0]);
        end
        if (mem_wr_en) begin
            ram[mem_addr[7:0]]         <= mem_d;
            ram_written[mem_addr[7:0]] <= 1'b1;
        end
    end

    typedef struct {
        logic [0:3]  rd;
        logic [0:3]  wr;
        logic [0:3]  stl;
        logic [11:0] a;
        logic [63:0] dv;
        logic [0:3]  exp_full;
        logic [0:3]  exp_valid;
        logic        exp_mrd;
        logic        exp_mwr;
        logic [11:0] exp_maddr;
        logic        qchk;
        int          qport;
        logic [63:0] qval;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [0:3] rd, input logic [0:3] wr, input logic [0:3] stl,
                                input logic [11:0] a, input logic [63:0] dv,
                                input logic [0:3] ef, input logic [0:3] ev,
                                input logic emrd, input logic emwr, input logic [11:0] ema,
                                input logic qchk, input int qport, input logic [63:0] qval);
        vec_t v;
        v.rd = rd; v.wr = wr; v.stl = stl; v.a = a; v.dv = dv;
        v.exp_full = ef; v.exp_valid = ev; v.exp_mrd = emrd; v.exp_mwr = emwr;
        v.exp_maddr = ema; v.qchk = qchk; v.qport = qport; v.qval = qval;
        return v;
    endfunction

    function automatic logic [63:0] q_slice(input int p);
        return q[(PORTS-1-p)*WIDTH +: WIDTH];
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [63:0] actual, input logic [63:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s[%0d]: got %h, expected %h", name, idx, actual, expected);
        end
    endtask

    // Port p gets address a+p and data dv+p so each port's traffic is distinguishable
    task automatic applyStimulus(input logic [0:3] rdv, input logic [0:3] wrv, input logic [0:3] stv,
                                 input logic [11:0] a, input logic [63:0] dv);
        rd_en = rdv;
        wr_en = wrv;
        stall = stv;
        for (int p = 0; p < PORTS; p++) begin
            addr[(PORTS-1-p)*AW +: AW]       = a + 12'(p);
            d[(PORTS-1-p)*WIDTH +: WIDTH]    = dv + 64'(p);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        num_compared   = 0;
        num_mismatched = 0;
        rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_full", 0, {60'd0, full}, 64'd0);
        checkOutput("rst_valid", 0, {60'd0, valid}, 64'd0);
        checkOutput("rst_mrd", 0, {63'd0, mem_rd_en}, 64'd0);
        checkOutput("rst_mwr", 0, {63'd0, mem_wr_en}, 64'd0);
        checkOutput("rst_maddr", 0, {52'd0, mem_addr}, 64'd0);
        checkOutput("rst_md", 0, mem_d, 64'd0);
        for (int p = 0; p < PORTS; p++) checkOutput("rst_q", p, q_slice(p), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: no RAM activity
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_mrd", i, {63'd0, mem_rd_en}, 64'd0);
            checkOutput("idle_mwr", i, {63'd0, mem_wr_en}, 64'd0);
        end

        // Four simultaneous reads from ptr=0, then port 0 write/read, then read-first rd+wr
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 12'h010, 64'd0, 4'b0111, 4'b0000, 1'b0, 1'b0, 12'h000, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0111, 4'b0000, 4'b0000, 12'h010, 64'd0, 4'b0011, 4'b0000, 1'b1, 1'b0, 12'h010, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 12'h010, 64'd0, 4'b0001, 4'b0000, 1'b1, 1'b0, 12'h011, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0001, 4'b0000, 4'b0000, 12'h010, 64'd0, 4'b0000, 4'b1000, 1'b1, 1'b0, 12'h012, 1'b1, 0, 64'hC0DE_0000_0000_0010));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h010, 64'd0, 4'b0000, 4'b0100, 1'b1, 1'b0, 12'h013, 1'b1, 1, 64'hC0DE_0000_0000_0011));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0010, 1'b0, 1'b0, 12'h013, 1'b1, 2, 64'hC0DE_0000_0000_0012));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0001, 1'b0, 1'b0, 12'h013, 1'b1, 3, 64'hC0DE_0000_0000_0013));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 12'h013, 1'b1, 3, 64'hC0DE_0000_0000_0013));
        vecs.push_back(mk(4'b0000, 4'b1000, 4'b0000, 12'h005, 64'hA5, 4'b0000, 4'b0000, 1'b0, 1'b0, 12'h013, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b1000, 4'b0000, 4'b0000, 12'h005, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b1, 12'h005, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 12'h005, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 12'h005, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b1000, 1'b0, 1'b0, 12'h005, 1'b1, 0, 64'hA5));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 12'h005, 1'b1, 0, 64'hA5));
        vecs.push_back(mk(4'b0000, 4'b1000, 4'b0000, 12'h007, 64'h11, 4'b0000, 4'b0000, 1'b0, 1'b0, 12'h005, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b1000, 4'b1000, 4'b0000, 12'h007, 64'h22, 4'b0000, 4'b0000, 1'b0, 1'b1, 12'h007, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 12'h007, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 12'h007, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b1000, 1'b0, 1'b0, 12'h007, 1'b1, 0, 64'h11));
        vecs.push_back(mk(4'b1000, 4'b0000, 4'b0000, 12'h007, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 12'h007, 1'b1, 0, 64'h11));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 12'h007, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 12'h007, 1'b0, 0, 64'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b1000, 1'b0, 1'b0, 12'h007, 1'b1, 0, 64'h22));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 12'h007, 1'b0, 0, 64'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].stl, vecs[i].a, vecs[i].dv);
            tick();
            checkOutput("vec_full", i, {60'd0, full}, {60'd0, vecs[i].exp_full});
            checkOutput("vec_valid", i, {60'd0, valid}, {60'd0, vecs[i].exp_valid});
            checkOutput("vec_mrd", i, {63'd0, mem_rd_en}, {63'd0, vecs[i].exp_mrd});
            checkOutput("vec_mwr", i, {63'd0, mem_wr_en}, {63'd0, vecs[i].exp_mwr});
            checkOutput("vec_maddr", i, {52'd0, mem_addr}, {52'd0, vecs[i].exp_maddr});
            if (vecs[i].qchk) begin
                checkOutput("vec_q", i, q_slice(vecs[i].qport), vecs[i].qval);
            end
        end

        // Stall on port 2: the second read waits until valid drains
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 12'h020, 64'd0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0010, 12'h020, 64'd0);
        n = 1;
        tick();
        while (!valid[2] && n < 9) begin
            n++;
            tick();
        end
        checkOutput("stall_first_latency", 0, 64'(n), 64'd3);
        checkOutput("stall_first_q", 0, q_slice(2), 64'hC0DE_0000_0000_0022);
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 12'h021, 64'd0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0010, 12'h021, 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_hold_full", i, {63'd0, full[2]}, 64'd1);
            checkOutput("stall_hold_mrd", i, {63'd0, mem_rd_en}, 64'd0);
            checkOutput("stall_hold_valid", i, {63'd0, valid[2]}, 64'd1);
            checkOutput("stall_hold_q", i, q_slice(2), 64'hC0DE_0000_0000_0022);
            tick();
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0);
        tick();
        checkOutput("stall_drop_valid", 0, {63'd0, valid[2]}, 64'd0);
        checkOutput("stall_drop_mrd", 0, {63'd0, mem_rd_en}, 64'd0);
        checkOutput("stall_drop_full", 0, {63'd0, full[2]}, 64'd0);
        tick();
        checkOutput("stall_issue_mrd", 0, {63'd0, mem_rd_en}, 64'd1);
        checkOutput("stall_issue_maddr", 0, {52'd0, mem_addr}, 64'h023);
        tick();
        tick();
        checkOutput("stall_second_valid", 0, {63'd0, valid[2]}, 64'd1);
        checkOutput("stall_second_q", 0, q_slice(2), 64'hC0DE_0000_0000_0023);
        tick();
        checkOutput("stall_second_clear", 0, {63'd0, valid[2]}, 64'd0);

        // Reset while requests are pending and a read is in flight
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 12'h040, 64'd0);
        tick();
        applyStimulus(4'b0111, 4'b0000, 4'b0000, 12'h040, 64'd0);
        tick();
        checkOutput("prerst_mrd", 0, {63'd0, mem_rd_en}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_full", 0, {60'd0, full}, 64'd0);
        checkOutput("midrst_valid", 0, {60'd0, valid}, 64'd0);
        checkOutput("midrst_mrd", 0, {63'd0, mem_rd_en}, 64'd0);
        checkOutput("midrst_maddr", 0, {52'd0, mem_addr}, 64'd0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("postrst_mrd", i, {63'd0, mem_rd_en}, 64'd0);
            checkOutput("postrst_mwr", i, {63'd0, mem_wr_en}, 64'd0);
            checkOutput("postrst_valid", i, {60'd0, valid}, 64'd0);
        end

        // Ports 0 and 3 write continuously from ptr=0
        applyStimulus(4'b0000, 4'b1001, 4'b0000, 12'h030, 64'h5000);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("arb_mwr", i, {63'd0, mem_wr_en}, 64'd1);
`ifdef SCRATCH_PAD_ARB_FIXED_PRIORITY_EN
            checkOutput("arb_maddr", i, {52'd0, mem_addr}, 64'h030);
            checkOutput("arb_full3", i, {63'd0, full[3]}, 64'd1);
`else
            checkOutput("arb_maddr", i, {52'd0, mem_addr}, (i % 2 == 0) ? 64'h030 : 64'h033);
            checkOutput("arb_full", i, {60'd0, full}, (i % 2 == 0) ? 64'h8 : 64'h1);
`endif
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 12'h000, 64'd0);
        repeat (4) tick();
        checkOutput("drain_mwr", 0, {63'd0, mem_wr_en}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
